// File: rtl/ram_write_arbiter.sv
// Write-port arbiter for a dual-port RAM: round-robin sharing between two
// valid/ready requesters plus a full-RAM clear engine.
module ram_write_arbiter #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    input  logic                  clear_req,
    output logic                  busy,
    output logic                  clear_done,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_write_addr,
    output logic [DATA_WIDTH-1:0] ram_write_data
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] clr_cnt_q;
    logic                  last_grant_q;
    logic                  ram_we_q;
    logic [ADDR_WIDTH-1:0] ram_addr_q;
    logic [DATA_WIDTH-1:0] ram_data_q;
    logic                  clear_done_q;

    logic                  accept_open;
    logic                  grant0;
    logic                  grant1;

    // On conflict the port that did not win the last transfer is granted.
    always_comb begin
        accept_open = (state_q == IDLE) && !clear_req;
        grant0      = req0_valid && (!req1_valid ||  last_grant_q);
        grant1      = req1_valid && (!req0_valid || !last_grant_q);
        req0_ready  = accept_open && grant0;
        req1_ready  = accept_open && grant1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            clr_cnt_q    <= '0;
            last_grant_q <= 1'b1;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_data_q   <= '0;
            clear_done_q <= 1'b0;
        end else begin
            ram_we_q     <= 1'b0;
            clear_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (clear_req) begin
                        state_q   <= CLEAR;
                        clr_cnt_q <= '0;
                    end else if (req0_ready) begin
                        ram_we_q     <= 1'b1;
                        ram_addr_q   <= req0_addr;
                        ram_data_q   <= req0_data;
                        last_grant_q <= 1'b0;
                    end else if (req1_ready) begin
                        ram_we_q     <= 1'b1;
                        ram_addr_q   <= req1_addr;
                        ram_data_q   <= req1_data;
                        last_grant_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    ram_we_q   <= 1'b1;
                    ram_addr_q <= clr_cnt_q;
                    ram_data_q <= CLEAR_VALUE;
                    // Leave on the last address so the counter never wraps mid-clear.
                    if (clr_cnt_q == '1) begin
                        state_q      <= IDLE;
                        clear_done_q <= 1'b1;
                        clr_cnt_q    <= '0;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy           = (state_q == CLEAR);
    assign clear_done     = clear_done_q;
    assign ram_we         = ram_we_q;
    assign ram_write_addr = ram_addr_q;
    assign ram_write_data = ram_data_q;

endmodule

// File: tb/tb_ram_write_arbiter.sv
// Directed self-checking bench for ram_write_arbiter with a 16-word RAM model.
module tb_ram_write_arbiter;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 8;

    logic          clk;
    logic          rst_n;
    logic          req0_valid;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_data;
    logic          req0_ready;
    logic          req1_valid;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_data;
    logic          req1_ready;
    logic          clear_req;
    logic          busy;
    logic          clear_done;
    logic          ram_we;
    logic [AW-1:0] ram_write_addr;
    logic [DW-1:0] ram_write_data;

    logic [DW-1:0] mem [16];

    int unsigned checks;
    int unsigned errors;

    ram_write_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .CLEAR_VALUE(8'h00)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req0_valid    (req0_valid),
        .req0_addr     (req0_addr),
        .req0_data     (req0_data),
        .req0_ready    (req0_ready),
        .req1_valid    (req1_valid),
        .req1_addr     (req1_addr),
        .req1_data     (req1_data),
        .req1_ready    (req1_ready),
        .clear_req     (clear_req),
        .busy          (busy),
        .clear_done    (clear_done),
        .ram_we        (ram_we),
        .ram_write_addr(ram_write_addr),
        .ram_write_data(ram_write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM write port behaviour: commits at the edge where ram_we is seen high.
    always @(posedge clk) begin
        if (ram_we) mem[ram_write_addr] <= ram_write_data;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        clear_req  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_eq("rst_we",   32'(ram_we), 32'd0);
        check_eq("rst_addr", 32'(ram_write_addr), 32'd0);
        check_eq("rst_data", 32'(ram_write_data), 32'd0);
        check_eq("rst_done", 32'(clear_done), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        // 1: single requester, one-cycle registered write
        req0_valid = 1'b1; req0_addr = 4'h5; req0_data = 8'hA5;
        #1;
        check_eq("t1_rdy0", 32'(req0_ready), 32'd1);
        check_eq("t1_rdy1", 32'(req1_ready), 32'd0);
        @(posedge clk); @(negedge clk);
        req0_valid = 1'b0;
        #1;
        check_eq("t1_we",   32'(ram_we), 32'd1);
        check_eq("t1_addr", 32'(ram_write_addr), 32'h5);
        check_eq("t1_data", 32'(ram_write_data), 32'hA5);
        tick();
        check_eq("t1_mem5", 32'(mem[5]), 32'hA5);
        check_eq("t1_we0",  32'(ram_we), 32'd0);

        // 2: both valid for 4 cycles from reset -> grants 0,1,0,1
        do_reset();
        req0_valid = 1'b1; req0_addr = 4'h1; req0_data = 8'h10;
        req1_valid = 1'b1; req1_addr = 4'h2; req1_data = 8'h20;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("t2_rdy0", 32'(req0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
            check_eq("t2_rdy1", 32'(req1_ready), (i % 2 == 1) ? 32'd1 : 32'd0);
            if (i > 0) begin
                check_eq("t2_we",   32'(ram_we), 32'd1);
                check_eq("t2_addr", 32'(ram_write_addr), (i % 2 == 1) ? 32'h1 : 32'h2);
            end
            @(posedge clk); @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        check_eq("t2_we4",   32'(ram_we), 32'd1);
        check_eq("t2_addr4", 32'(ram_write_addr), 32'h2);
        check_eq("t2_data4", 32'(ram_write_data), 32'h20);
        tick();
        check_eq("t2_we_off", 32'(ram_we), 32'd0);

        // 3: port 1 won last; port 1 alone twice, then both -> port 0
        req1_valid = 1'b1; req1_addr = 4'h6; req1_data = 8'h66;
        for (int i = 0; i < 2; i++) begin
            #1;
            check_eq("t3_solo1", 32'(req1_ready), 32'd1);
            @(posedge clk); @(negedge clk);
        end
        req0_valid = 1'b1; req0_addr = 4'h7; req0_data = 8'h77;
        #1;
        check_eq("t3_rdy0", 32'(req0_ready), 32'd1);
        check_eq("t3_rdy1", 32'(req1_ready), 32'd0);
        @(posedge clk); @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        check_eq("t3_addr", 32'(ram_write_addr), 32'h7);
        tick();

        // 4: fill with 0xFF through port 0, then full clear
        req0_valid = 1'b1; req0_data = 8'hFF;
        for (int a = 0; a < 16; a++) begin
            req0_addr = 4'(a);
            @(posedge clk); @(negedge clk);
        end
        req0_valid = 1'b0;
        tick();
        tick();
        check_eq("t4_mem_ff", 32'(mem[9]), 32'hFF);
        clear_req = 1'b1;
        @(posedge clk); @(negedge clk);
        clear_req = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) begin
            check_eq("t4_busy", 32'(busy), 32'd1);
            check_eq("t4_done", 32'(clear_done), 32'd0);
            if (i > 0) begin
                check_eq("t4_we",   32'(ram_we), 32'd1);
                check_eq("t4_addr", 32'(ram_write_addr), 32'(i - 1));
                check_eq("t4_data", 32'(ram_write_data), 32'h00);
            end
            tick();
        end
        check_eq("t4_busy_off", 32'(busy), 32'd0);
        check_eq("t4_done_hi",  32'(clear_done), 32'd1);
        check_eq("t4_we_last",  32'(ram_we), 32'd1);
        check_eq("t4_addr_last", 32'(ram_write_addr), 32'hF);
        tick();
        check_eq("t4_done_lo", 32'(clear_done), 32'd0);
        check_eq("t4_we_end",  32'(ram_we), 32'd0);
        for (int a = 0; a < 16; a++) check_eq("t4_mem_clr", 32'(mem[a]), 32'h00);

        // 5: clear_req beats a same-cycle request; request lands after the clear
        clear_req = 1'b1;
        req0_valid = 1'b1; req0_addr = 4'h3; req0_data = 8'h5A;
        #1;
        check_eq("t5_rdy_blocked", 32'(req0_ready), 32'd0);
        @(posedge clk); @(negedge clk);
        clear_req = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) begin
            check_eq("t5_rdy_clear", 32'(req0_ready), 32'd0);
            tick();
        end
        check_eq("t5_busy_off", 32'(busy), 32'd0);
        check_eq("t5_rdy_after", 32'(req0_ready), 32'd1);
        @(posedge clk); @(negedge clk);
        req0_valid = 1'b0;
        #1;
        check_eq("t5_we",   32'(ram_we), 32'd1);
        check_eq("t5_addr", 32'(ram_write_addr), 32'h3);
        check_eq("t5_data", 32'(ram_write_data), 32'h5A);
        tick();
        check_eq("t5_mem3", 32'(mem[3]), 32'h5A);
        check_eq("t5_mem4", 32'(mem[4]), 32'h00);

        // 6: reset mid-clear, then restart from address 0
        clear_req = 1'b1;
        @(posedge clk); @(negedge clk);
        clear_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); @(negedge clk);
        end
        #1;
        check_eq("t6_at7", 32'(ram_write_addr), 32'h7);
        rst_n = 1'b0;
        #1;
        check_eq("t6_busy", 32'(busy), 32'd0);
        check_eq("t6_we",   32'(ram_we), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("t6_no_done", 32'(clear_done), 32'd0);
            @(posedge clk); @(negedge clk);
        end
        clear_req = 1'b1;
        @(posedge clk); @(negedge clk);
        clear_req = 1'b0;
        tick();
        check_eq("t6_restart_we",   32'(ram_we), 32'd1);
        check_eq("t6_restart_addr", 32'(ram_write_addr), 32'h0);
        check_eq("t6_restart_busy", 32'(busy), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
